// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a glitch-filtered clock, inter-edge timeout and a
// first-word-fall-through FIFO of {err, byte} entries read over valid/ready.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned T_TIMEOUT  = 50000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                CLK_PS2_IN,
    input  logic                                DATA_PS2_IN,
    input  logic                                READ_ENABLE,
    input  logic                                ERR_CLEAR,
    output logic [7:0]                          RX_DATA,
    output logic [1:0]                          RX_ERR,
    output logic                                RX_VALID,
    input  logic                                RX_READY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     FIFO_COUNT,
    output logic                                OVERFLOW,
    output logic                                TIMEOUT
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(T_TIMEOUT + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StPush
    } state_e;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt_clk;
    logic          filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          sampled;

    state_e        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_err;
    logic          stop_err;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          in_frame;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [9:0]    head;

    // Bus idles high, so the synchronisers reset to 1 to avoid a spurious edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], CLK_PS2_IN};
            dat_sync  <= {dat_sync[0], DATA_PS2_IN};
            filt_prev <= filt_clk;
            if (clk_sync[1] != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall     = filt_prev & ~filt_clk;
    assign sampled  = dat_sync[1];
    assign in_frame = (state == StData) || (state == StParity) || (state == StStop);
    assign tmo_hit  = in_frame && !fall && (tmo_cnt == TW'(T_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= StIdle;
            bit_cnt  <= '0;
            shift    <= '0;
            par_err  <= 1'b0;
            stop_err <= 1'b0;
            tmo_cnt  <= '0;
            TIMEOUT  <= 1'b0;
        end else begin
            if (fall || state == StIdle) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (ERR_CLEAR) begin
                TIMEOUT <= 1'b0;
            end
            if (tmo_hit) begin
                TIMEOUT <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (fall && !sampled && READ_ENABLE) begin
                        state    <= StData;
                        bit_cnt  <= '0;
                        par_err  <= 1'b0;
                        stop_err <= 1'b0;
                    end
                end
                StData: begin
                    if (fall) begin
                        shift   <= {sampled, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= StParity;
                        end
                    end else if (tmo_hit) begin
                        state <= StIdle;
                    end
                end
                StParity: begin
                    if (fall) begin
                        par_err <= (sampled != ~^shift);
                        state   <= StStop;
                    end else if (tmo_hit) begin
                        state <= StIdle;
                    end
                end
                StStop: begin
                    if (fall) begin
                        stop_err <= ~sampled;
                        state    <= StPush;
                    end else if (tmo_hit) begin
                        state <= StIdle;
                    end
                end
                StPush: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign push  = (state == StPush);
    assign pop   = (count != '0) && RX_READY;
    assign full  = (count == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= {stop_err, par_err, shift};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end

            if (ERR_CLEAR) begin
                OVERFLOW <= 1'b0;
            end
            if (push && full && !pop) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign RX_VALID   = (count != '0);
    assign RX_DATA    = RX_VALID ? head[7:0] : 8'h00;
    assign RX_ERR     = RX_VALID ? head[9:8] : 2'b00;
    assign FIFO_COUNT = count;

endmodule
